// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - forwarding select, load-use / multi-cycle stall and mul/div tracking
module fwd_hazard_unit #(
  parameter int REG_AW = 4,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_md_op,
  input  logic [REG_AW-1:0] id_ex_rs,
  input  logic [REG_AW-1:0] id_ex_rt,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic              id_ex_mem_read,
  input  logic              id_ex_md_start,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              ex_mem_reg_write,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic              mem_wb_reg_write,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall,
  output logic              md_busy,
  output logic              md_done,
  output logic [REG_AW-1:0] md_rd_q,
  output logic [CNT_W-1:0]  stall_count,
  output logic              md_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // The start cycle plus MD_LAT-1 further cycles: BUSY covers MD_LAT-1 cycles, counting down to 0.
  localparam logic [3:0] CNT_LOAD = 4'(MD_LAT - 2);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [REG_AW-1:0] rd_d;
  logic              err_set;

  logic ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b, md_hit_a, md_hit_b;
  logic load_use, md_hold, md_struct, md_counting;

  // Forward-source match terms; an EX/MEM write to the same index (even r0) shadows MEM/WB.
  always_comb begin
    ex_hit_a = ex_mem_reg_write && (ex_mem_rd == id_ex_rs);
    ex_hit_b = ex_mem_reg_write && (ex_mem_rd == id_ex_rt);
    wb_hit_a = mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == id_ex_rs) && !ex_hit_a;
    wb_hit_b = mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == id_ex_rt) && !ex_hit_b;
    md_hit_a = md_done && (md_rd_q != '0) && (md_rd_q == id_ex_rs);
    md_hit_b = md_done && (md_rd_q != '0) && (md_rd_q == id_ex_rt);
  end

  // Priority select of the operand source: EX/MEM, then MEM/WB, then the mul/div result.
  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (ex_hit_a && (ex_mem_rd != '0)) forward_a = 2'b10;
    else if (wb_hit_a)                 forward_a = 2'b01;
    else if (md_hit_a)                 forward_a = 2'b11;
    if (ex_hit_b && (ex_mem_rd != '0)) forward_b = 2'b10;
    else if (wb_hit_b)                 forward_b = 2'b01;
    else if (md_hit_b)                 forward_b = 2'b11;
  end

  // Hazard detection; the mul/div hold drops on the last BUSY cycle so the consumer meets DONE in EX.
  always_comb begin
    md_counting = (state_q == BUSY) && (cnt_q != 4'd0);
    load_use    = id_ex_mem_read && (id_ex_rd != '0) &&
                  ((id_ex_rd == id_rs) || (id_ex_rd == id_rt));
    md_hold     = md_counting && (md_rd_q != '0) &&
                  ((md_rd_q == id_rs) || (md_rd_q == id_rt) ||
                   (md_rd_q == (id_reg_write ? id_rd : '0)));
    md_struct   = md_counting && id_md_op;
    stall       = load_use | md_hold | md_struct;
  end

  // Mul/div sequencer next-state: a start while BUSY is dropped and flagged.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = md_rd_q;
    err_set = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (id_ex_md_start) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
          rd_d    = id_ex_rd;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        err_set = id_ex_md_start;
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, counter, destination tag and sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      md_rd_q <= '0;
      md_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_rd_q <= rd_d;
      if (err_set) md_err <= 1'b1;
    end
  end

  // Saturating count of stalled cycles; overlapping hazards are one stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             stall_count <= '0;
    else if (stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
  end

  assign md_busy = (state_q == BUSY);
  assign md_done = (state_q == DONE);

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_rs, id_rt, id_rd, id_ex_rs, id_ex_rt, id_ex_rd, ex_mem_rd, mem_wb_rd, md_rd_q;
  logic       id_reg_write, id_md_op, id_ex_mem_read, id_ex_md_start;
  logic       ex_mem_reg_write, mem_wb_reg_write;
  logic [1:0] forward_a, forward_b;
  logic       stall, md_busy, md_done, md_err;
  logic [3:0] stall_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_AW(4), .MD_LAT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_reg_write(id_reg_write), .id_md_op(id_md_op),
    .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_md_start(id_ex_md_start),
    .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
    .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write),
    .forward_a(forward_a), .forward_b(forward_b), .stall(stall),
    .md_busy(md_busy), .md_done(md_done), .md_rd_q(md_rd_q),
    .stall_count(stall_count), .md_err(md_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; id_rd = 0; id_reg_write = 0; id_md_op = 0;
    id_ex_rs = 0; id_ex_rt = 0; id_ex_rd = 0; id_ex_mem_read = 0; id_ex_md_start = 0;
    ex_mem_rd = 0; ex_mem_reg_write = 0; mem_wb_rd = 0; mem_wb_reg_write = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #3;
    check("rst_busy", 32'(md_busy), 32'd0);
    check("rst_done", 32'(md_done), 32'd0);
    check("rst_err", 32'(md_err), 32'd0);
    check("rst_cnt", 32'(stall_count), 32'd0);
    check("rst_rdq", 32'(md_rd_q), 32'd0);
    check("idle_fa", 32'(forward_a), 32'd0);
    check("idle_fb", 32'(forward_b), 32'd0);
    check("idle_stall", 32'(stall), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // forwarding priority
    ex_mem_rd = 3; ex_mem_reg_write = 1; mem_wb_rd = 3; mem_wb_reg_write = 1; id_ex_rs = 3;
    #1 check("fwd_exmem", 32'(forward_a), 32'd2);
    ex_mem_reg_write = 0;
    #1 check("fwd_memwb", 32'(forward_a), 32'd1);
    ex_mem_rd = 0; ex_mem_reg_write = 1; mem_wb_rd = 0; id_ex_rs = 0;
    #1 check("fwd_r0", 32'(forward_a), 32'd0);
    ex_mem_rd = 5; mem_wb_rd = 3; id_ex_rt = 3;
    #1 check("fwd_b_memwb", 32'(forward_b), 32'd1);
    ex_mem_rd = 3;
    #1 check("fwd_b_exmem", 32'(forward_b), 32'd2);
    clear_inputs();
    tick();

    // load-use
    id_ex_mem_read = 1; id_ex_rd = 0; id_rt = 0;
    #1 check("lu_r0_nostall", 32'(stall), 32'd0);
    id_ex_rd = 5; id_rt = 5;
    #1 check("lu_stall", 32'(stall), 32'd1);
    tick();
    clear_inputs();
    #1 check("lu_release", 32'(stall), 32'd0);
    check("lu_count", 32'(stall_count), 32'd1);

    // mul/div: start in cycle 0 with rd=7
    id_ex_md_start = 1; id_ex_rd = 7;
    tick();                                              // cycle 1
    id_ex_md_start = 0; id_ex_rd = 7; id_ex_mem_read = 1; id_rs = 7;   // load-use and md_hold together
    #1 check("md_busy_c1", 32'(md_busy), 32'd1);
    check("md_stall_c1", 32'(stall), 32'd1);
    check("md_rdq", 32'(md_rd_q), 32'd7);
    tick();                                              // cycle 2
    id_ex_mem_read = 0; id_ex_rd = 0;
    #1 check("md_busy_c2", 32'(md_busy), 32'd1);
    check("md_stall_c2", 32'(stall), 32'd1);
    check("md_cnt_once", 32'(stall_count), 32'd2);
    tick();                                              // cycle 3
    check("md_busy_c3", 32'(md_busy), 32'd1);
    check("md_release_c3", 32'(stall), 32'd0);
    check("md_done_c3", 32'(md_done), 32'd0);
    tick();                                              // cycle 4
    id_rs = 0; id_ex_rs = 7;
    #1 check("md_done_c4", 32'(md_done), 32'd1);
    check("md_busy_c4", 32'(md_busy), 32'd0);
    check("md_fwd11", 32'(forward_a), 32'd3);
    check("md_cnt_c4", 32'(stall_count), 32'd3);
    tick();                                              // cycle 5
    id_ex_rs = 0;
    check("md_done_c5", 32'(md_done), 32'd0);

    // overrun start in cycle 2, then restart in DONE
    id_ex_md_start = 1; id_ex_rd = 9;
    tick();                                              // cycle 1
    id_ex_md_start = 0;
    tick();                                              // cycle 2
    id_ex_md_start = 1; id_ex_rd = 10;
    tick();                                              // cycle 3
    id_ex_md_start = 0; id_ex_rd = 0;
    check("err_set", 32'(md_err), 32'd1);
    check("err_rdq_kept", 32'(md_rd_q), 32'd9);
    check("err_busy", 32'(md_busy), 32'd1);
    tick();                                              // cycle 4
    check("err_done_c4", 32'(md_done), 32'd1);
    id_ex_md_start = 1; id_ex_rd = 11;
    tick();                                              // new cycle 1
    id_ex_md_start = 0; id_ex_rd = 0; id_md_op = 1;
    #1 check("restart_busy", 32'(md_busy), 32'd1);
    check("restart_rdq", 32'(md_rd_q), 32'd11);
    check("struct_stall", 32'(stall), 32'd1);
    tick();                                              // cycle 2
    id_md_op = 0;
    tick();                                              // cycle 3
    check("restart_nodone_c3", 32'(md_done), 32'd0);
    tick();                                              // cycle 4
    check("restart_done_c4", 32'(md_done), 32'd1);
    check("err_sticky", 32'(md_err), 32'd1);
    check("struct_count", 32'(stall_count), 32'd4);
    tick();

    // reset during BUSY
    id_ex_md_start = 1; id_ex_rd = 12;
    tick();
    id_ex_md_start = 0; id_ex_rd = 0;
    tick();
    #3 rst = 1'b1;
    #1 check("arst_busy", 32'(md_busy), 32'd0);
    check("arst_err", 32'(md_err), 32'd0);
    check("arst_cnt", 32'(stall_count), 32'd0);
    check("arst_rdq", 32'(md_rd_q), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("arst_no_done", 32'(md_done), 32'd0);
    end

    // saturation of the 4-bit stall counter
    id_ex_mem_read = 1; id_ex_rd = 5; id_rs = 5;
    for (int i = 0; i < 14; i++) tick();
    check("sat_14", 32'(stall_count), 32'd14);
    for (int i = 0; i < 6; i++) tick();
    check("sat_20", 32'(stall_count), 32'd15);
    tick();
    check("sat_hold", 32'(stall_count), 32'd15);
    clear_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL have parameter REG_AW, default 4, meaning register-address width; register 0 is hardwired zero.
REQ-002 The block SHALL have parameter MD_LAT, default 4, meaning multi-cycle (mul/div) latency in cycles, legal range 2..15.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high: clk input 1 rising-edge clock; rst input 1 async active-high reset.
REQ-005 The block SHALL have ports id_rs, id_rt, input REG_AW, meaning ID-stage source registers.
REQ-006 The block SHALL have ports id_rd input REG_AW, id_reg_write input 1, and id_md_op input 1, meaning ID destination, write enable, and multi-cycle opcode.
REQ-007 The block SHALL have ports id_ex_rs, id_ex_rt, id_ex_rd input REG_AW, meaning EX-stage registers.
REQ-008 The block SHALL have ports id_ex_mem_read input 1 (EX load), id_ex_md_start input 1 (EX holds multi-cycle op).
REQ-009 The block SHALL have ports ex_mem_rd input REG_AW, ex_mem_reg_write input 1, mem_wb_rd input REG_AW, and mem_wb_reg_write input 1.
REQ-010 The block SHALL have ports forward_a and forward_b, output 2, with encoding 00 regfile, 10 EX/MEM, 01 MEM/WB, 11 multi-cycle result.
REQ-011 The block SHALL have port stall, output 1, meaning hold PC and IF/ID and insert a bubble into ID/EX.
REQ-012 The block SHALL have ports md_busy output 1, md_done output 1 (result valid, write-back this cycle), and md_rd_q output REG_AW.
REQ-013 The block SHALL have ports stall_count output CNT_W (saturating) and md_err output 1 (sticky overrun flag).

Function
REQ-014 Forwarding SHALL be combinational, with priority EX/MEM > MEM/WB > multi-cycle; a source requires its write enable (md_done for 11), a nonzero rd, and rd equal to id_ex_rs (A) or id_ex_rt (B).
REQ-015 A MEM/WB match SHALL be suppressed whenever an EX/MEM match with write enable exists for the same operand, even if ex_mem_rd is 0.
REQ-016 The multi-cycle FSM SHALL have states IDLE, BUSY, and DONE, with a down-counter cnt of 4 bits.
REQ-017 When id_ex_md_start=1 in IDLE or DONE, the FSM SHALL go to BUSY with cnt=MD_LAT-2 and md_rd_q=id_ex_rd.
REQ-018 In BUSY, the FSM SHALL go to DONE if cnt==0, and otherwise decrement cnt.
REQ-019 DONE SHALL last one cycle and then return to IDLE, unless REQ-017 applies in that cycle.
REQ-020 md_done SHALL be 1 exactly in DONE, i.e. MD_LAT cycles after the start cycle; md_busy SHALL be 1 in BUSY.
REQ-021 If id_ex_md_start=1 in BUSY, the start SHALL be ignored, the FSM state SHALL be unchanged, and md_err SHALL be set until reset.
REQ-022 load_use SHALL be asserted when id_ex_mem_read=1, id_ex_rd!=0, and id_ex_rd equals id_rs or id_rt.
REQ-023 md_hold SHALL be asserted when state==BUSY, cnt!=0, md_rd_q!=0, and md_rd_q equals id_rs, id_rt, or (id_reg_write ? id_rd : 0).
REQ-024 md_struct SHALL be asserted when state==BUSY, cnt!=0, and id_md_op=1.
REQ-025 stall SHALL equal load_use | md_hold | md_struct.
REQ-026 Because the hold is released at the last BUSY cycle, the dependent instruction SHALL reach EX in the DONE cycle and take forward code 11.
REQ-027 stall_count SHALL increment by 1 on each clk edge where stall=1, and SHALL hold at all-ones (no wrap).
REQ-028 Simultaneous load_use and md hazards SHALL produce a single stall, counted once.

Reset
REQ-029 While rst=1, asynchronously: state=IDLE, cnt=0, md_rd_q=0, md_busy=0, md_done=0, md_err=0, stall_count=0.
REQ-030 Reset mid-BUSY SHALL abort the operation, with no md_done pulse afterward.
REQ-031 With all write enables, mem_read, and md inputs at 0, forward_a/b SHALL be 00 and stall SHALL be 0.

Verification
REQ-032 The bench SHALL cover: ex_mem_rd=3 with write, mem_wb_rd=3 with write, and id_ex_rs=3 -> forward_a=10; with ex_mem write=0 -> 01; with rd=0 -> 00.
REQ-033 The bench SHALL cover: id_ex_mem_read=1, id_ex_rd=5, id_rt=5 -> stall=1 for one cycle, and stall_count increments by 1.
REQ-034 The bench SHALL cover, with MD_LAT=4: start at cycle 0 with rd=7 -> md_busy in cycles 1-3 and md_done in cycle 4; id_rs=7 stalls in cycles 1-2 and releases in cycle 3; then id_ex_rs=7 in cycle 4 -> forward_a=11.
REQ-035 The bench SHALL cover: id_ex_md_start in cycle 2 of BUSY -> md_err=1 and sticky, with md_done still in cycle 4; a start issued in DONE -> accepted, with md_done 4 cycles later.
REQ-036 The bench SHALL cover: rst pulsed during BUSY -> all outputs at reset values immediately, with no md_done pulse afterward.
REQ-037 The bench SHALL cover, with CNT_W=4: 20 stall cycles -> stall_count=15, holding at 15.
